// File: rtl/queen_solver.sv
// N-queens backtracking search controller with a time-shared pairwise safety checker.
// Walks one (candidate, placed-queen) pair per cycle and pauses on every solution.

module is_safe (
   input  logic [2:0] row1,
   input  logic [2:0] column1,
   input  logic [2:0] row2,
   input  logic [2:0] column2,
   output logic       safe
);

   function automatic logic [2:0] abs_diff(input logic [2:0] a, input logic [2:0] b);
      logic signed [3:0] d;
      d = $signed({1'b0, a}) - $signed({1'b0, b});
      return (d < 0) ? 3'(-d) : 3'(d);
   endfunction

   assign safe = (column1 != column2) &&
                 (abs_diff(row1, row2) != abs_diff(column1, column2));

endmodule

module queen_solver #(
   parameter int N  = 8,
   parameter int CW = 7
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic            abort,
   output logic            busy,
   output logic            done,
   output logic            found,
   output logic [3*N-1:0]  queens,
   output logic [CW-1:0]   sol_count
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CHECK,
      S_NEXT,
      S_BACK,
      S_SOLVED,
      S_EXHAUSTED
   } state_t;

   localparam logic [2:0]    LAST    = 3'(N - 1);
   localparam logic [CW-1:0] CNT_MAX = '1;

   state_t     state, state_nx;
   logic [2:0] r, r_nx;
   logic [2:0] k, k_nx;
   logic [2:0] col [8];
   logic       clr_all, clr_row, inc_col;
   logic       cnt_clr, cnt_inc;
   logic       safe;
   logic [2:0] r_inc;

   assign r_inc = r + 3'd1;

   is_safe u_is_safe (
      .row1    (r),
      .column1 (col[r]),
      .row2    (k),
      .column2 (col[k]),
      .safe    (safe)
   );

   always_comb begin
      state_nx = state;
      r_nx     = r;
      k_nx     = k;
      clr_all  = 1'b0;
      clr_row  = 1'b0;
      inc_col  = 1'b0;
      cnt_clr  = 1'b0;
      cnt_inc  = 1'b0;
      busy     = (state == S_CHECK) || (state == S_NEXT) || (state == S_BACK);
      if (abort) begin
         state_nx = S_IDLE;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  clr_all  = 1'b1;
                  cnt_clr  = 1'b1;
                  r_nx     = 3'd0;
                  k_nx     = 3'd0;
                  state_nx = S_CHECK;
               end
            end
            S_CHECK: begin
               // k reaching r means every earlier row accepted the candidate
               if (k == r) begin
                  if (r == LAST) begin
                     cnt_inc  = 1'b1;
                     state_nx = S_SOLVED;
                  end else begin
                     clr_row = 1'b1;
                     r_nx    = r_inc;
                     k_nx    = 3'd0;
                  end
               end else if (safe) begin
                  k_nx = k + 3'd1;
               end else begin
                  state_nx = S_NEXT;
               end
            end
            S_NEXT: begin
               if (col[r] == LAST) begin
                  state_nx = S_BACK;
               end else begin
                  inc_col  = 1'b1;
                  k_nx     = 3'd0;
                  state_nx = S_CHECK;
               end
            end
            S_BACK: begin
               if (r == 3'd0) begin
                  state_nx = S_EXHAUSTED;
               end else begin
                  r_nx     = r - 3'd1;
                  state_nx = S_NEXT;
               end
            end
            S_SOLVED: begin
               // resuming simply advances the last row through the backtrack path
               if (start) begin
                  r_nx     = LAST;
                  state_nx = S_NEXT;
               end
            end
            S_EXHAUSTED: state_nx = S_IDLE;
            default:     state_nx = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         r         <= 3'd0;
         k         <= 3'd0;
         done      <= 1'b0;
         found     <= 1'b0;
         sol_count <= '0;
         for (int i = 0; i < 8; i++) begin
            col[i] <= 3'd0;
         end
      end else begin
         state <= state_nx;
         r     <= r_nx;
         k     <= k_nx;
         done  <= ((state_nx == S_SOLVED) && (state != S_SOLVED)) ||
                  (state_nx == S_EXHAUSTED);
         found <= (state_nx == S_SOLVED);
         if (cnt_clr) begin
            sol_count <= '0;
         end else if (cnt_inc && (sol_count != CNT_MAX)) begin
            sol_count <= sol_count + 1'b1;
         end
         if (clr_all) begin
            for (int i = 0; i < 8; i++) begin
               col[i] <= 3'd0;
            end
         end else if (clr_row) begin
            col[r_inc] <= 3'd0;
         end else if (inc_col) begin
            col[r] <= col[r] + 3'd1;
         end
      end
   end

   always_comb begin
      queens = '0;
      for (int i = 0; i < N; i++) begin
         queens[3*i +: 3] = col[i];
      end
   end

endmodule
